// File: rtl/rr_hold_arbiter_pkg.sv
// Shared definitions for the round-robin hold arbiter.
//   state_t  : arbiter FSM states (IDLE = nobody owns the resource,
//              BUSY = one requester owns it).
//   next_idx : wrap-around increment of a requester index, modulo n.
//              This works for any n, including n that is not a power of two.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// Combinational round-robin picker.
// It finds the first eligible requester, scanning ptr, ptr+1, ... modulo N.
// Ports:
//   request : per-requester request bits
//   ptr     : index that has the highest priority
//   excl    : requesters that may not win (for example, the current owner)
//   result  : one-hot winner, or all zeros
//   index   : winner index, or 0 when valid=0
//   valid   : a winner exists
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   request,
  input  logic [IDW-1:0] ptr,
  input  logic [N-1:0]   excl,
  output logic [N-1:0]   result,
  output logic [IDW-1:0] index,
  output logic           valid
);

  logic [N-1:0]   eligible;
  logic [2*N-1:0] doubled;
  logic [2*N-1:0] masked;

  // The eligible bits are concatenated twice. Bits below ptr in the low copy
  // are masked off, so the lowest remaining set bit is the first requester at
  // or after ptr. Wrap-around hits are found in the upper copy. Because
  // ptr < N, the upper copy is never masked, so any eligible bit is found.
  always_comb begin
    eligible = request & ~excl;
    doubled  = {eligible, eligible};
    masked   = doubled & ~(((2*N)'(1) << ptr) - (2*N)'(1));
    valid    = |eligible;
    index    = '0;
    result   = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) begin
        index = (i >= N) ? IDW'(i - N) : IDW'(i);
      end
    end
    if (valid) begin
      result = N'(1) << index;
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a hold limit, for N requesters sharing one resource.
// The owner keeps the grant while it keeps requesting. It is pre-empted after
// MAX_HOLD consecutive cycles if another requester is waiting.
// Ports:
//   clk         : clock; all logic is on the rising edge
//   reset       : synchronous, active-high
//   request     : per-requester request levels
//   grant       : registered one-hot grant, or all zeros
//   grant_valid : high when any grant bit is set
//   grant_id    : index of the current owner; 0 when nothing is granted
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   request,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  localparam int HCW = $clog2(MAX_HOLD + 1);

  state_t         state_q, state_n;
  logic [IDW-1:0] ptr_q, ptr_n;
  logic [IDW-1:0] owner_q, owner_n;
  logic [HCW-1:0] hold_q, hold_n;
  logic [N-1:0]   grant_q, grant_n;
  logic [IDW-1:0] gid_q, gid_n;

  logic [N-1:0]   owner_mask;
  logic           owner_req;
  logic [N-1:0]   pick_onehot;
  logic [IDW-1:0] pick_idx;
  logic           pick_valid;
  logic           take;

  // While BUSY, the owner is always excluded from the pick. On release its
  // request is already 0, so the same picker covers both release and
  // pre-emption.
  assign owner_mask = (state_q == BUSY) ? (N'(1) << owner_q) : '0;
  assign owner_req  = request[owner_q];

  rr_pick #(.N(N)) u_pick (
    .request (request),
    .ptr     (ptr_q),
    .excl    (owner_mask),
    .result  (pick_onehot),
    .index   (pick_idx),
    .valid   (pick_valid)
  );

  // Next-state logic. Each case only decides whether a new grant happens.
  // A new grant always loads the same values: the winner becomes owner,
  // ptr moves past the winner, and the hold count restarts at 1.
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    owner_n = owner_q;
    hold_n  = hold_q;
    grant_n = grant_q;
    gid_n   = gid_q;
    take    = 1'b0;
    case (state_q)
      IDLE: take = pick_valid;
      BUSY: begin
        if (!owner_req) begin
          if (pick_valid) begin
            take = 1'b1;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            gid_n   = '0;
          end
        end else if (hold_q == HCW'(MAX_HOLD)) begin
          take = pick_valid;
        end else begin
          hold_n = hold_q + 1'b1;
        end
      end
    endcase
    if (take) begin
      state_n = BUSY;
      owner_n = pick_idx;
      ptr_n   = IDW'(next_idx(int'(pick_idx), N));
      hold_n  = HCW'(1);
      grant_n = pick_onehot;
      gid_n   = pick_idx;
    end
  end

  // State and output registers. Reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      owner_q <= owner_n;
      hold_q  <= hold_n;
      grant_q <= grant_n;
      gid_q   <= gid_n;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Self-checking bench for rr_hold_arbiter with N=4 and MAX_HOLD=8.
// A behavioural model of the arbitration rules runs alongside the DUT.
// Directed scenarios also check hand-computed literal grants.
module tb_rr_hold_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] request = '0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;

  int checks = 0;
  int errors = 0;

  // Model state.
  bit           model_on = 1'b0;
  bit           m_busy;
  int           m_ptr, m_owner, m_hold, m_win;
  logic [N-1:0] m_grant;
  int           m_id;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  // Model update on each rising edge, followed by a compare 1 ns later.
  always @(posedge clk) begin
    if (reset) begin
      model_on = 1'b1;
      m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_hold = 0;
      m_grant = '0; m_id = 0;
    end else if (model_on) begin
      m_win = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_win < 0 && request[j] && !(m_busy && j == m_owner)) m_win = j;
      end
      if (!m_busy || !request[m_owner] || m_hold == MAX_HOLD) begin
        if (m_win >= 0) begin
          m_busy = 1'b1; m_owner = m_win; m_ptr = (m_win + 1) % N; m_hold = 1;
          m_grant = '0; m_grant[m_win] = 1'b1; m_id = m_win;
        end else if (m_busy && !request[m_owner]) begin
          m_busy = 1'b0; m_grant = '0; m_id = 0;
        end
      end else begin
        m_hold = m_hold + 1;
      end
    end
    #1;
    if (model_on) begin
      checks++;
      if (grant !== m_grant || grant_valid !== (m_grant != '0) || int'(grant_id) != m_id) begin
        errors++;
        $display("[TB] FAIL model t=%0t: got grant=%b valid=%b id=%0d, expected grant=%b valid=%b id=%0d",
                 $time, grant, grant_valid, grant_id, m_grant, (m_grant != '0), m_id);
      end
    end
  end

  // Drive one cycle of inputs on the falling edge, then wait until the
  // outputs have settled after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] req);
    @(negedge clk);
    reset   = rst;
    request = req;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] expGrant, input int expId);
    checks++;
    if (grant !== expGrant || grant_valid !== (expGrant != '0) || int'(grant_id) != expId) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%b valid=%b id=%0d, expected grant=%b valid=%b id=%0d",
               name, grant, grant_valid, grant_id, expGrant, (expGrant != '0), expId);
    end
  endtask

  initial begin
    logic [N-1:0] exp;
    $display("[TB] starting rr_hold_arbiter bench");

    // Hold reset with every request set: nothing may be granted.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 4'b1111);
      checkOutput("reset_hold", 4'b0000, 0);
    end

    // Full contention: each requester gets 8 cycles, starting from requester 0.
    for (int c = 0; c < 33; c++) begin
      applyStimulus(1'b0, 4'b1111);
      exp = 4'b0001 << ((c / MAX_HOLD) % N);
      checkOutput("contention", exp, (c / MAX_HOLD) % N);
    end

    // Owner 0 drops its request while requester 3 waits: handover with no gap.
    applyStimulus(1'b0, 4'b1000);
    checkOutput("release_handover", 4'b1000, 3);

    // Owner 3 drops; from ptr=0 the first request found is 2.
    // Requester 2 then holds alone for 20 cycles, well past MAX_HOLD.
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 4'b0100);
      checkOutput("single_holder", 4'b0100, 2);
    end

    // Owner 2 drops with no other request: go idle.
    applyStimulus(1'b0, 4'b0000);
    checkOutput("idle", 4'b0000, 0);

    // ptr=3: requester 3 is idle, so the scan wraps to 0.
    applyStimulus(1'b0, 4'b0011);
    checkOutput("ptr_wrap", 4'b0001, 0);

    // Owner 0 drops; from ptr=1 the first request found is 2.
    applyStimulus(1'b0, 4'b0100);
    checkOutput("pre_reset_burst", 4'b0100, 2);

    // Reset in the middle of a burst clears the grant on the next edge.
    applyStimulus(1'b1, 4'b0100);
    checkOutput("reset_mid_burst", 4'b0000, 0);
    applyStimulus(1'b1, 4'b1111);
    checkOutput("reset_mid_hold", 4'b0000, 0);

    // After reset, ptr is back at 0.
    applyStimulus(1'b0, 4'b1111);
    checkOutput("post_reset_grant", 4'b0001, 0);

    // A few more contended cycles, checked by the model only.
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 4'b1010);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Parameterised round-robin arbiter for N requesters that share one resource. It holds a grant while the owner keeps requesting, and pre-empts the owner after MAX_HOLD cycles when another requester is waiting. It generalises the two-requester arbiter used in our SVA environment and sits between the requesting masters and the shared resource. All grant outputs are registered and one-hot.

## Interface
- N, default 4: number of requesters, minimum 2.
- MAX_HOLD, default 8: maximum consecutive cycles an owner keeps a contended grant, minimum 1.
- IDW, default $clog2(N): width of grant_id (derived, not overridable).

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- request  input  N  per-requester request level; bit i belongs to requester i.
- grant  output  N  registered one-hot grant, or all zeros.
- grant_valid  output  1  equals |grant.
- grant_id  output  IDW  index of the current owner; 0 when grant_valid=0.

## Operation
- Internal state:
  - state: IDLE or BUSY.
  - ptr (IDW): the requester with highest priority at the next arbitration.
  - owner (IDW): the current owner.
  - hold_cnt: counts 1..MAX_HOLD and saturates.
- Round-robin pick: the first i with request[i]=1, scanning ptr, ptr+1, … in modulo-N order.
- Every grant sets ptr = (winner+1) mod N and hold_cnt = 1.
- IDLE:
  - Any request set: grant the round-robin pick and go to BUSY.
  - Otherwise: grant stays 0.
- BUSY, case 1 (release): request[owner]=0.
  - Arbitrate over the remaining requests using the ptr set at the owner's grant.
  - If a winner exists, grant it on the same edge. There is no idle bubble.
  - If there is no winner, go to IDLE and drive grant=0.
- BUSY, case 2 (pre-empt): request[owner]=1, hold_cnt==MAX_HOLD, and another request bit is set.
  - Grant the round-robin pick excluding the owner.
- BUSY, case 3 (sole owner at limit): request[owner]=1, hold_cnt==MAX_HOLD, and no other request is set.
  - Keep the grant; hold_cnt stays at MAX_HOLD.
- BUSY, case 4 (otherwise): keep the grant and increment hold_cnt.
- With MAX_HOLD=1, a contended grant rotates every cycle.
- Request changes between edges are ignored. Only the value sampled at posedge matters.
- Index arithmetic wraps modulo N, including non-power-of-two N. Indices N..2^IDW-1 are never produced.

## Timing
- Latency: a request sampled at edge t can appear on grant after edge t. No grant output is combinational from request.
- Reset is sampled at posedge. At the edge after reset=1:
  - grant=0, grant_valid=0, grant_id=0.
  - state=IDLE, ptr=0, owner=0, hold_cnt=0.
- reset |-> ##1 grant==0 must hold. This includes reset asserted in the middle of a burst.
- During reset, requests are ignored. Arbitration starts at the first edge with reset=0, with ptr=0.
- Release and pre-emption hand over on a single edge. The old owner loses the grant and the new owner gains it after the same posedge.
- Invariants:
  - $onehot0(grant) at all times.
  - grant_id is consistent with grant.
  - grant[i] implies request[i] was 1 at the granting edge.
  - A continuously requesting line receives a grant within (N-1)*MAX_HOLD+1 cycles.

## Structure
- Package arb_pkg:
  - state enum {IDLE, BUSY}.
  - Helper function next_idx(idx, N) for the modulo-N increment.
- Sub-module rr_pick (combinational):
  - Inputs: request, ptr, and an excl mask.
  - Outputs: one-hot result, index, and valid.
  - Implemented as a double-width masked priority encoder.
- rr_hold_arbiter contains the FSM, ptr, owner and hold_cnt registers, and the registered outputs.

## Test plan
- Reset: hold reset for 10 cycles with request=4'b1111.
  - grant=0000 on every cycle during reset.
  - First grant after reset drops is 0001.
- Single holder: request=4'b0100 for 20 cycles.
  - grant=0100 for all 20 cycles.
  - No drop at MAX_HOLD=8.
- Full contention: request=4'b1111 held, MAX_HOLD=8.
  - grant is 0001 for 8 cycles, then 0010 ×8, 0100 ×8, 1000 ×8, then 0001 again.
- Release handover: owner 0 drops its request while request=1000.
  - Next edge: grant=1000, grant_id=3.
  - No all-zero cycle in between.
- Idle and pointer: owner 2 drops and all requests are 0.
  - grant=0000, grant_valid=0.
  - Then request=4'b0011: grant=0001, because ptr=3 wraps to 0.
- Reset mid-burst: assert reset while grant=0100.
  - grant=0000 on the next edge.
  - After release with request=1111: grant=0001.
